sel_mux_pipe: RTL and testbench
===============================

Name: sel_mux_pipe

Overview:
- Parametrised N:1 word selector with a registered, flow-controlled output stage for the pipelined datapath.
- Intended uses: PC-source selection, forwarding selection, and write-back selection wherever a pipeline stall must hold the selected value.
- Captures {selected word} under a valid/ready handshake.
- Contains a 2-entry skid buffer, so the input-side ready is a registered signal with no combinational path from OutReady.

Parameters:
- WIDTH, 32: data word width in bits.
- NUM_IN, 4: number of selectable inputs; legal range 2..16.
- SEL_W, $clog2(NUM_IN): width of Src.
- RESET_VAL, 32'd4: value of Out while no word has been accepted since reset or flush; truncated or zero-extended to WIDTH.

Ports:
- Clk, input, 1: rising-edge clock.
- Rst_n, input, 1: asynchronous active-low reset.
- Flush, input, 1: synchronous pipeline flush; discards buffered words.
- In, input, NUM_IN*WIDTH: packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- Src, input, SEL_W: select index.
- InValid, input, 1: In and Src are valid this cycle.
- InReady, output, 1: block can accept a word this cycle.
- Out, output, WIDTH: selected word at the head of the buffer.
- OutValid, output, 1: Out holds a valid word.
- OutReady, input, 1: consumer accepts Out this cycle.

Behaviour:
- Reset (Rst_n low, asynchronous):
  - Out = RESET_VAL, OutValid = 0, InReady = 1.
  - Both buffer entries are emptied.
- Accept: InValid & InReady at a rising edge.
  - The word In[Src*WIDTH +: WIDTH] is selected and stored.
  - If Src >= NUM_IN, the stored word is RESET_VAL.
- Drain: OutValid & OutReady at a rising edge pops the head entry.
- Latency: an accepted word appears on Out with OutValid=1 in the next cycle. There is no combinational path from In/Src to Out.
- States, tracked by occupancy count:
  - EMPTY: InReady=1, OutValid=0. Accept moves to ONE.
  - ONE: InReady=1, OutValid=1.
    - Accept and drain together: stay in ONE; the head is replaced by the new word.
    - Accept only: go to FULL; the new word goes to the skid entry.
    - Drain only: go to EMPTY.
  - FULL: InReady=0, OutValid=1.
    - Drain: the skid entry moves to the head; go to ONE.
    - InValid while InReady=0 is ignored, and the producer must hold its word.
- Out while EMPTY: holds the last word drained, or RESET_VAL after reset or flush. Out does not change while OutValid=0 except on reset or flush.
- Flush:
  - At the edge: return to EMPTY, OutValid=0, Out=RESET_VAL, InReady=1.
  - Any InValid on the same edge is dropped.
  - Flush overrides simultaneous accept and drain.
- Ordering and integrity: strict FIFO order, no duplication, no loss while Flush=0.
- InReady depends only on registered occupancy.
- Rst_n asserting mid-transfer: every word in flight is discarded immediately, without waiting for a clock edge.
- Behaviour when Src changes while InValid=1 and InReady=0 is the producer's responsibility; the block samples Src only on accept.

Optional Feature:
- Macro SEL_MUX_PIPE_SELERR_EN.
- When defined, the block gains an extra output port SelErr (1 bit), which is a sticky flag:
  - Set on an accept with Src >= NUM_IN.
  - Cleared only by Rst_n or Flush.
  - Set and clear on the same edge: the clear wins.
- When undefined, the port is absent and an out-of-range Src silently yields RESET_VAL.
- The datapath is identical in both builds.

Decomposition:
- Shared package sel_mux_pkg holds:
  - The occupancy typedef (EMPTY/ONE/FULL, 2 bits).
  - Localparam DEFAULT_RESET_VAL = 32'd4.
  - A function computing the select width.
- One sub-module, sel_mux_comb: purely combinational N:1 indexed select with the out-of-range default.
- The top level instantiates sel_mux_comb plus the skid-buffer control.

Test Plan:
- Reset: hold Rst_n=0, then release → Out=32'd4, OutValid=0, InReady=1. Assert Rst_n mid-stream → all outputs return to reset values at once, without a clock edge.
- Streaming:
  - Stimulus: NUM_IN=4; In = {D,C,B,A} = {0x40,0x30,0x20,0x10}; Src = 2,0,3,1 on consecutive cycles; OutReady=1.
  - Response: Out = 0x30, 0x10, 0x40, 0x20, each one cycle after accept; InReady stays 1.
- Backpressure:
  - Stimulus: OutReady=0, present 3 words.
  - Response: first two words accepted, InReady=0 on the third, OutValid=1, Out = first word.
  - Then raise OutReady → words drain in order, and the third is accepted only after InReady returns to 1.
- Flush:
  - Stimulus: FULL, then Flush=1 together with InValid=1 and OutReady=1.
  - Response: next cycle OutValid=0, Out=32'd4, InReady=1; the flushed and the concurrent words never appear.
- Out-of-range select:
  - Stimulus: NUM_IN=3, Src=3, In word 0 = 0xAA.
  - Response: Out=32'd4 (not 0xAA).
  - With SEL_MUX_PIPE_SELERR_EN defined: SelErr=1, and it stays 1 through later legal accepts until Flush.
- Randomised width:
  - Stimulus: WIDTH=8, NUM_IN=16, random Src/InValid/OutReady for 10k cycles.
  - Response: a scoreboard sees in-order, lossless output, and InReady never depends on same-cycle OutReady.

Source files
------------

// File: rtl/sel_mux_pkg.sv
// Shared definitions for the sel_mux_pipe selector stage:
// occupancy encoding, default reset word and select-width helper.
package sel_mux_pkg;

   // Occupancy of the 2-entry skid buffer
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_t;

   // Word shown on the output before anything has been accepted
   localparam logic [31:0] DEFAULT_RESET_VAL = 32'd4;

   // Width of the select index for a given number of inputs (at least 1 bit)
   function automatic int sel_width(input int num_in);
      return (num_in > 1) ? $clog2(num_in) : 1;
   endfunction

endpackage

// File: rtl/sel_mux_comb.sv
// Purely combinational N:1 word selector. An index outside 0..NUM_IN-1
// yields DEFAULT_WORD instead of any input.
module sel_mux_comb #(
   parameter int WIDTH = 32,
   parameter int NUM_IN = 4,
   parameter int SEL_W = 2,
   parameter logic [WIDTH-1:0] DEFAULT_WORD = '0
)(
   input  logic [NUM_IN*WIDTH-1:0] words,
   input  logic [SEL_W-1:0]        src,
   output logic [WIDTH-1:0]        word
);

   // Scan every legal index so an out-of-range src never slices past the bus
   always_comb begin
      word = DEFAULT_WORD;
      for (int k = 0; k < NUM_IN; k++) begin
         if (src == SEL_W'(k)) begin
            word = words[k*WIDTH +: WIDTH];
         end
      end
   end

endmodule

// File: rtl/sel_mux_pipe.sv
// Registered N:1 word selector with a valid/ready output stage built on a
// 2-entry skid buffer (head + skid). InReady comes straight from registered
// occupancy, so it never depends on the same-cycle OutReady.
// Optional build macro: SEL_MUX_PIPE_SELERR_EN adds the sticky SelErr output
// flagging an accepted out-of-range Src; the datapath is the same either way.
module sel_mux_pipe
   import sel_mux_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NUM_IN = 4,
   parameter int SEL_W = sel_width(NUM_IN),
   parameter logic [31:0] RESET_VAL = DEFAULT_RESET_VAL
)(
   input  logic                    Clk,
   input  logic                    Rst_n,
   input  logic                    Flush,
   input  logic [NUM_IN*WIDTH-1:0] In,
   input  logic [SEL_W-1:0]        Src,
   input  logic                    InValid,
   output logic                    InReady,
   output logic [WIDTH-1:0]        Out,
   output logic                    OutValid,
   input  logic                    OutReady
`ifdef SEL_MUX_PIPE_SELERR_EN
   ,
   output logic                    SelErr
`endif
);

   localparam logic [WIDTH-1:0] RESET_WORD = WIDTH'(RESET_VAL);

   occ_t             occ;
   occ_t             occ_next;
   logic [WIDTH-1:0] head;
   logic [WIDTH-1:0] head_next;
   logic [WIDTH-1:0] skid;
   logic [WIDTH-1:0] skid_next;
   logic [WIDTH-1:0] sel_word;
   logic             accept;
   logic             drain;

   sel_mux_comb #(
      .WIDTH        (WIDTH),
      .NUM_IN       (NUM_IN),
      .SEL_W        (SEL_W),
      .DEFAULT_WORD (RESET_WORD)
   ) u_sel (
      .words (In),
      .src   (Src),
      .word  (sel_word)
   );

   assign InReady  = (occ != FULL);
   assign OutValid = (occ != EMPTY);
   assign Out      = head;
   assign accept   = InValid & InReady;
   assign drain    = OutValid & OutReady;

   // Occupancy and buffer registers; reset empties both entries immediately
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         occ  <= EMPTY;
         head <= RESET_WORD;
         skid <= RESET_WORD;
      end else begin
         occ  <= occ_next;
         head <= head_next;
         skid <= skid_next;
      end
   end

   // Next occupancy and entry contents; flush beats any accept or drain
   always_comb begin
      occ_next  = occ;
      head_next = head;
      skid_next = skid;
      if (Flush) begin
         occ_next  = EMPTY;
         head_next = RESET_WORD;
      end else begin
         case (occ)
            EMPTY: begin
               if (accept) begin
                  head_next = sel_word;
                  occ_next  = ONE;
               end
            end
            ONE: begin
               if (accept && drain) begin
                  head_next = sel_word;
               end else if (accept) begin
                  skid_next = sel_word;
                  occ_next  = FULL;
               end else if (drain) begin
                  occ_next  = EMPTY;
               end
            end
            FULL: begin
               if (drain) begin
                  head_next = skid;
                  occ_next  = ONE;
               end
            end
            default: begin
               occ_next  = EMPTY;
               head_next = RESET_WORD;
            end
         endcase
      end
   end

`ifdef SEL_MUX_PIPE_SELERR_EN
   logic sel_err;
   logic src_bad;

   assign src_bad = (32'(Src) >= 32'(NUM_IN));
   assign SelErr  = sel_err;

   // Sticky out-of-range flag; flush clearing wins over a same-edge set
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         sel_err <= 1'b0;
      end else if (Flush) begin
         sel_err <= 1'b0;
      end else if (accept && src_bad) begin
         sel_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_sel_mux_pipe.sv
// Self-checking bench for sel_mux_pipe. Two instances share all stimulus:
// a 4-input one and a 3-input one where Src=3 is out of range.
module tb_sel_mux_pipe;

   localparam int W = 32;
   localparam logic [W-1:0] RV = 32'd4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic           flush;
   logic           in_valid;
   logic           out_ready;
   logic [4*W-1:0] in_bus;
   logic [1:0]     src;
   logic           in_ready;
   logic           out_valid;
   logic [W-1:0]   out_word;
   logic           in_ready3;
   logic           out_valid3;
   logic [W-1:0]   out_word3;
`ifdef SEL_MUX_PIPE_SELERR_EN
   logic           sel_err;
   logic           sel_err3;
`endif

   int checks = 0;
   int failures = 0;

   // Reference model: expected buffer contents as queues
   logic [W-1:0] q4[$];
   logic [W-1:0] q3[$];
   logic [W-1:0] last4 = RV;
   logic [W-1:0] last3 = RV;
   logic         err3_m = 1'b0;
   logic         m_acc;
   logic         m_drn;

   always #5 clk = ~clk;

   sel_mux_pipe #(.WIDTH(W), .NUM_IN(4)) dut (
      .Clk(clk), .Rst_n(rst_n), .Flush(flush), .In(in_bus), .Src(src),
      .InValid(in_valid), .InReady(in_ready), .Out(out_word),
      .OutValid(out_valid), .OutReady(out_ready)
`ifdef SEL_MUX_PIPE_SELERR_EN
      , .SelErr(sel_err)
`endif
   );

   sel_mux_pipe #(.WIDTH(W), .NUM_IN(3)) dut3 (
      .Clk(clk), .Rst_n(rst_n), .Flush(flush), .In(in_bus[3*W-1:0]), .Src(src),
      .InValid(in_valid), .InReady(in_ready3), .Out(out_word3),
      .OutValid(out_valid3), .OutReady(out_ready)
`ifdef SEL_MUX_PIPE_SELERR_EN
      , .SelErr(sel_err3)
`endif
   );

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle of inputs, return 1ns after the capturing edge
   task automatic applyStimulus(input logic iv, input logic [1:0] s,
                                input logic ordy, input logic fl);
      in_valid  = iv;
      src       = s;
      out_ready = ordy;
      flush     = fl;
      @(posedge clk);
      #1;
   endtask

   // Model update: a FIFO of at most two words, Out holds last drained word
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n || flush) begin
         q4.delete();
         q3.delete();
         last4  = RV;
         last3  = RV;
         err3_m = 1'b0;
      end else begin
         m_acc = in_valid && (q4.size() < 2);
         m_drn = out_ready && (q4.size() > 0);
         if (m_drn) begin
            last4 = q4.pop_front();
            last3 = q3.pop_front();
         end
         if (m_acc) begin
            q4.push_back(in_bus[src*W +: W]);
            q3.push_back((src < 2'd3) ? in_bus[src*W +: W] : RV);
            if (src == 2'd3) err3_m = 1'b1;
         end
      end
   end

   // Compare both instances against the model every cycle
   always @(negedge clk) begin
      checkOutput("m_valid4", 32'(out_valid), 32'(q4.size() > 0));
      checkOutput("m_ready4", 32'(in_ready), 32'(q4.size() < 2));
      checkOutput("m_out4", out_word, (q4.size() > 0) ? q4[0] : last4);
      checkOutput("m_valid3", 32'(out_valid3), 32'(q3.size() > 0));
      checkOutput("m_ready3", 32'(in_ready3), 32'(q3.size() < 2));
      checkOutput("m_out3", out_word3, (q3.size() > 0) ? q3[0] : last3);
`ifdef SEL_MUX_PIPE_SELERR_EN
      checkOutput("m_selerr4", 32'(sel_err), 32'd0);
      checkOutput("m_selerr3", 32'(sel_err3), 32'(err3_m));
`endif
   end

   initial begin
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      src       = 2'd0;
      in_bus    = {32'h40, 32'h30, 32'h20, 32'h10};

      // Reset
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      checkOutput("rst_out", out_word, 32'd4);
      checkOutput("rst_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_out3", out_word3, 32'd4);
`ifdef SEL_MUX_PIPE_SELERR_EN
      checkOutput("rst_selerr3", 32'(sel_err3), 32'd0);
`endif

      // Streaming Src = 2,0,3,1 with OutReady high
      applyStimulus(1'b1, 2'd2, 1'b1, 1'b0);
      checkOutput("str0_out", out_word, 32'h30);
      checkOutput("str0_valid", 32'(out_valid), 32'd1);
      checkOutput("str0_ready", 32'(in_ready), 32'd1);
      applyStimulus(1'b1, 2'd0, 1'b1, 1'b0);
      checkOutput("str1_out", out_word, 32'h10);
      applyStimulus(1'b1, 2'd3, 1'b1, 1'b0);
      checkOutput("str2_out", out_word, 32'h40);
      checkOutput("str2_out3", out_word3, 32'd4);
`ifdef SEL_MUX_PIPE_SELERR_EN
      checkOutput("str2_selerr3", 32'(sel_err3), 32'd1);
`endif
      applyStimulus(1'b1, 2'd1, 1'b1, 1'b0);
      checkOutput("str3_out", out_word, 32'h20);
      checkOutput("str3_ready", 32'(in_ready), 32'd1);
`ifdef SEL_MUX_PIPE_SELERR_EN
      checkOutput("str3_selerr3", 32'(sel_err3), 32'd1);
`endif
      applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
      checkOutput("str_hold_out", out_word, 32'h20);
      checkOutput("str_hold_valid", 32'(out_valid), 32'd0);

      // Backpressure: three words offered with OutReady low
      applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
      checkOutput("bp0_ready", 32'(in_ready), 32'd1);
      applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
      checkOutput("bp1_ready", 32'(in_ready), 32'd0);
      checkOutput("bp1_valid", 32'(out_valid), 32'd1);
      checkOutput("bp1_out", out_word, 32'h10);
      applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
      checkOutput("bp2_ready", 32'(in_ready), 32'd0);
      checkOutput("bp2_out", out_word, 32'h10);
      applyStimulus(1'b1, 2'd2, 1'b1, 1'b0);
      checkOutput("bp3_out", out_word, 32'h20);
      checkOutput("bp3_ready", 32'(in_ready), 32'd1);
      applyStimulus(1'b1, 2'd2, 1'b1, 1'b0);
      checkOutput("bp4_out", out_word, 32'h30);
      checkOutput("bp4_valid", 32'(out_valid), 32'd1);
      applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
      checkOutput("bp5_valid", 32'(out_valid), 32'd0);
      checkOutput("bp5_out", out_word, 32'h30);

      // Flush from FULL with concurrent accept and drain
      applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
      checkOutput("fl_full_ready", 32'(in_ready), 32'd0);
      applyStimulus(1'b1, 2'd3, 1'b1, 1'b1);
      checkOutput("fl_valid", 32'(out_valid), 32'd0);
      checkOutput("fl_out", out_word, 32'd4);
      checkOutput("fl_ready", 32'(in_ready), 32'd1);
`ifdef SEL_MUX_PIPE_SELERR_EN
      checkOutput("fl_selerr3", 32'(sel_err3), 32'd0);
`endif
      applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
      checkOutput("fl_after_valid", 32'(out_valid), 32'd0);
      checkOutput("fl_after_out", out_word, 32'd4);

      // Out-of-range select on the 3-input instance
      in_bus = {32'h40, 32'h30, 32'h20, 32'hAA};
      applyStimulus(1'b1, 2'd3, 1'b1, 1'b0);
      checkOutput("oor_out3", out_word3, 32'd4);
      checkOutput("oor_out4", out_word, 32'h40);
      applyStimulus(1'b1, 2'd0, 1'b1, 1'b0);
      checkOutput("oor_legal_out3", out_word3, 32'hAA);
`ifdef SEL_MUX_PIPE_SELERR_EN
      checkOutput("oor_selerr3", 32'(sel_err3), 32'd1);
`endif
      applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);

      // Asynchronous reset in the middle of a full buffer
      applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checkOutput("arst_valid", 32'(out_valid), 32'd0);
      checkOutput("arst_ready", 32'(in_ready), 32'd1);
      checkOutput("arst_out", out_word, 32'd4);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Random traffic, model checked every cycle
      for (int i = 0; i < 4000; i++) begin
         in_bus = {$urandom, $urandom, $urandom, $urandom};
         out_ready = 1'b0;
         #1 checkOutput("rnd_ready_ordy0", 32'(in_ready), 32'(q4.size() < 2));
         out_ready = 1'b1;
         #1 checkOutput("rnd_ready_ordy1", 32'(in_ready), 32'(q4.size() < 2));
         applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
      end

      applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
      applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
